// File: rtl/lane_deskew_ctrl.sv
// lane_deskew_ctrl: timestamps per-lane deskew markers and drives per-lane delay codes plus lock/error status
module lane_deskew_ctrl #(
  parameter int LANES = 4,
  parameter int data_width = 8,
  parameter int symbol_count_width = 4,
  parameter int delay_width = 3,
  parameter int MAX_SKEW = 6,
  parameter logic [data_width-1:0] MARKER = 8'hAA
) (
  input  logic                                RX_CLK,
  input  logic                                rst,
  input  logic                                Soft_RST_blocks,
  input  logic                                EN_LTSSM,
  input  logic                                GEN,
  input  logic                                relock,
  input  logic [LANES*data_width-1:0]         RX_Data,
  input  logic [LANES*symbol_count_width-1:0] count,
  input  logic [LANES-1:0]                    block_type,
  input  logic [LANES-1:0]                    valid,
  output logic [LANES*delay_width-1:0]        delay_select,
  output logic                                deskew_done,
  output logic                                deskew_error
);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [LANES-1:0] hit, new_hit, arrived_q, arrived_d;
  logic [LANES-1:0][delay_width-1:0] stamp_q, stamp_d, dly_q, dly_d;
  logic [delay_width-1:0] lmax;
  logic [delay_width:0] timer_q, timer_d;
  logic started_q, started_d, done_q, done_d, err_q, err_d;
  logic active;
  assign active = EN_LTSSM & GEN;
  for (genvar i = 0; i < LANES; i++) begin : g_hit
    assign hit[i] = valid[i] & block_type[i] & (count[i*symbol_count_width +: symbol_count_width] == '0)
                    & (RX_Data[i*data_width +: data_width] == MARKER);
  end
  always_ff @(posedge RX_CLK) begin
    if (rst | Soft_RST_blocks) begin
      state_q   <= IDLE;
      arrived_q <= '0;
      stamp_q   <= '0;
      dly_q     <= '0;
      timer_q   <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      stamp_q   <= stamp_d;
      dly_q     <= dly_d;
      timer_q   <= timer_d;
      started_q <= started_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    stamp_d   = stamp_q;
    dly_d     = dly_q;
    timer_d   = timer_q;
    started_d = started_q;
    done_d    = done_q;
    err_d     = 1'b0;
    new_hit   = hit & ~arrived_q;
    lmax      = '0;
    if (!active) begin
      state_d   = IDLE;
      arrived_d = '0;
      stamp_d   = '0;
      dly_d     = '0;
      timer_d   = '0;
      started_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          for (int l = 0; l < LANES; l++)
            if (new_hit[l]) stamp_d[l] = started_q ? timer_q[delay_width-1:0] : '0;
          arrived_d = arrived_q | new_hit;
          if (started_q) timer_d = timer_q + (delay_width+1)'(1);
          else if (|new_hit) begin
            started_d = 1'b1;
            timer_d   = (delay_width+1)'(1);
          end
          for (int l = 0; l < LANES; l++)
            if (stamp_d[l] > lmax) lmax = stamp_d[l];
          if (&arrived_d) begin
            for (int l = 0; l < LANES; l++) dly_d[l] = lmax - stamp_d[l];
            done_d  = 1'b1;
            state_d = LOCKED;
          end else if (started_q && timer_q == (delay_width+1)'(MAX_SKEW)) begin
            err_d     = 1'b1;
            arrived_d = '0;
            stamp_d   = '0;
            timer_d   = '0;
            started_d = 1'b0;
          end
        end
        LOCKED: if (relock) begin
          state_d   = MEASURE;
          arrived_d = '0;
          stamp_d   = '0;
          dly_d     = '0;
          timer_d   = '0;
          started_d = 1'b0;
          done_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    delay_select = dly_q;
    deskew_done  = done_q;
    deskew_error = err_q;
  end
endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// tb_lane_deskew_ctrl: directed and random stimulus checked every cycle against an arrival-time model
module tb_lane_deskew_ctrl;
  logic RX_CLK = 1'b0;
  logic rst = 1'b1, Soft_RST_blocks = 1'b0, EN_LTSSM = 1'b0, GEN = 1'b0, relock = 1'b0;
  logic [31:0] RX_Data = '0;
  logic [15:0] count = '0;
  logic [3:0] block_type = '0, valid = '0;
  logic [11:0] delay_select;
  logic deskew_done, deskew_error;
  int tests = 0, fails = 0, cyc = 0, mode = 0, start = -1, mx = 0;
  int arr[4] = '{-1, -1, -1, -1};
  logic [11:0] e_ds = '0;
  logic e_done = 1'b0, e_err = 1'b0, chk_en = 1'b0, all_in = 1'b0;
  logic [3:0] hv;

  lane_deskew_ctrl dut (
    .RX_CLK(RX_CLK), .rst(rst), .Soft_RST_blocks(Soft_RST_blocks), .EN_LTSSM(EN_LTSSM),
    .GEN(GEN), .relock(relock), .RX_Data(RX_Data), .count(count), .block_type(block_type),
    .valid(valid), .delay_select(delay_select), .deskew_done(deskew_done), .deskew_error(deskew_error)
  );

  always #5 RX_CLK = ~RX_CLK;

  task automatic clr();
    for (int i = 0; i < 4; i++) arr[i] = -1;
    start = -1;
  endtask

  // model: lanes record the cycle of their first marker; skew is the spread of those cycles
  always @(posedge RX_CLK) begin
    for (int i = 0; i < 4; i++)
      hv[i] = valid[i] && block_type[i] && count[i*4 +: 4] == 4'd0 && RX_Data[i*8 +: 8] == 8'hAA;
    e_err = 1'b0;
    if (rst || Soft_RST_blocks || !(EN_LTSSM && GEN)) begin
      mode = 0; clr(); e_ds = '0; e_done = 1'b0;
    end else if (mode == 0) mode = 1;
    else if (mode == 2) begin
      if (relock) begin mode = 1; clr(); e_ds = '0; e_done = 1'b0; end
    end else begin
      for (int i = 0; i < 4; i++)
        if (hv[i] && arr[i] < 0) begin
          arr[i] = cyc;
          if (start < 0) start = cyc;
        end
      all_in = 1'b1; mx = 0;
      for (int i = 0; i < 4; i++)
        if (arr[i] < 0) all_in = 1'b0;
        else if (arr[i] > mx) mx = arr[i];
      if (all_in) begin
        for (int i = 0; i < 4; i++) e_ds[i*3 +: 3] = 3'(mx - arr[i]);
        e_done = 1'b1; mode = 2;
      end else if (start >= 0 && cyc - start == 6) begin
        e_err = 1'b1; clr();
      end
    end
    cyc++;
  end

  always @(negedge RX_CLK) if (chk_en) begin
    tests++;
    if ({delay_select, deskew_done, deskew_error} !== {e_ds, e_done, e_err}) begin
      fails++;
      $display("FAIL cycle_check @%0d: ds=%h done=%b err=%b, expected ds=%h done=%b err=%b",
               cyc, delay_select, deskew_done, deskew_error, e_ds, e_done, e_err);
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] h);
    for (int i = 0; i < 4; i++) begin
      if (h[i]) begin
        valid[i] = 1'b1; block_type[i] = 1'b1; count[i*4 +: 4] = 4'd0; RX_Data[i*8 +: 8] = 8'hAA;
      end else begin
        valid[i] = 1'($urandom); block_type[i] = 1'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          count[i*4 +: 4] = 4'($urandom_range(1, 15)); RX_Data[i*8 +: 8] = 8'($urandom);
        end else begin
          count[i*4 +: 4] = 4'd0; RX_Data[i*8 +: 8] = 8'h55;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] h);
    drive(h);
    @(negedge RX_CLK);
  endtask

  task automatic near(input logic v, input logic bt, input logic [3:0] c, input logic [7:0] d);
    drive(4'b0000);
    valid[0] = v; block_type[0] = bt; count[3:0] = c; RX_Data[7:0] = d;
    @(negedge RX_CLK);
  endtask

  initial begin
    step(4'b0000); step(4'b0000);
    chk_en = 1'b1;
    pin("reset_ds", {20'd0, delay_select}, 32'd0);
    pin("reset_done", {31'd0, deskew_done}, 32'd0);
    rst = 1'b0; EN_LTSSM = 1'b1; GEN = 1'b1;
    step(4'b0000);
    step(4'b1111);
    pin("all_same_ds", {20'd0, delay_select}, 32'd0);
    pin("all_same_done", {31'd0, deskew_done}, 32'd1);
    relock = 1'b1; step(4'b0000); relock = 1'b0;
    pin("relock_clears_done", {31'd0, deskew_done}, 32'd0);
    step(4'b0001); step(4'b1000); step(4'b0010); step(4'b0000); step(4'b0000);
    pin("skew_not_done_yet", {31'd0, deskew_done}, 32'd0);
    step(4'b0100);
    pin("model_skew_ds", {20'd0, e_ds}, 32'h81D);
    pin("skew_ds", {20'd0, delay_select}, 32'h81D);
    pin("skew_done", {31'd0, deskew_done}, 32'd1);
    EN_LTSSM = 1'b0; relock = 1'b1; step(4'b0000); relock = 1'b0;
    pin("disable_ds", {20'd0, delay_select}, 32'd0);
    pin("disable_done", {31'd0, deskew_done}, 32'd0);
    EN_LTSSM = 1'b1; step(4'b0000);
    step(4'b0111);
    for (int k = 0; k < 5; k++) step(4'b0000);
    pin("no_err_early", {31'd0, deskew_error}, 32'd0);
    step(4'b0000);
    pin("overflow_err", {31'd0, deskew_error}, 32'd1);
    pin("overflow_done", {31'd0, deskew_done}, 32'd0);
    step(4'b1111);
    pin("restart_err_cleared", {31'd0, deskew_error}, 32'd0);
    pin("restart_done", {31'd0, deskew_done}, 32'd1);
    pin("restart_ds", {20'd0, delay_select}, 32'd0);
    relock = 1'b1; step(4'b0000); relock = 1'b0;
    near(1'b1, 1'b1, 4'd3, 8'hAA);
    near(1'b1, 1'b0, 4'd0, 8'hAA);
    near(1'b0, 1'b1, 4'd0, 8'hAA);
    near(1'b1, 1'b1, 4'd0, 8'hE1);
    step(4'b1111);
    pin("near_marker_ds", {20'd0, delay_select}, 32'd0);
    pin("near_marker_done", {31'd0, deskew_done}, 32'd1);
    relock = 1'b1; step(4'b0000); relock = 1'b0;
    step(4'b0011);
    rst = 1'b1; step(4'b1100);
    pin("midrst_ds", {20'd0, delay_select}, 32'd0);
    pin("midrst_done", {31'd0, deskew_done}, 32'd0);
    rst = 1'b0; step(4'b0000);
    step(4'b1111);
    pin("post_rst_done", {31'd0, deskew_done}, 32'd1);
    pin("post_rst_ds", {20'd0, delay_select}, 32'd0);
    for (int k = 0; k < 600; k++) begin
      logic [3:0] h;
      rst = ($urandom_range(0, 149) == 0);
      Soft_RST_blocks = ($urandom_range(0, 149) == 0);
      EN_LTSSM = ($urandom_range(0, 49) != 0);
      GEN = ($urandom_range(0, 79) != 0);
      relock = ($urandom_range(0, 14) == 0);
      for (int i = 0; i < 4; i++) h[i] = ($urandom_range(0, 4) == 0);
      step(h);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
